// File: rtl/memory_access_stage.sv
// Memory stage: runs one data-memory load/store per instruction over a req/ack handshake
// and hands the results to the MemoryWriteback register. Abort timer built only with MEM_TIMEOUT_EN.
module memory_access_stage #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_wbs,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic              in_ni,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              out_valid,
    output logic              wbs_out,
    output logic              ni_out,
    output logic [DATA_W-1:0] memData_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic              mem_err
);

    // state    | meaning
    // S_IDLE   | accepting instructions; non-memory ops complete straight from here
    // S_ACCESS | memory request outstanding, upstream stalled until ack (or abort)
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t            r_state;
    logic              r_we;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wbs;
    logic              r_ni;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_out_valid;
    logic              r_mem_err;
    logic              w_tmr_zero;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Down-counter preloaded while idle; reaching zero without an ack ends the access.
    logic [CNT_W-1:0] r_tmr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (r_state == S_IDLE) begin
            r_tmr <= CNT_W'(TIMEOUT - 1);
        end else if (!dmem_ack && (r_tmr != '0)) begin
            r_tmr <= r_tmr - 1'b1;
        end
    end

    assign w_tmr_zero = (r_tmr == '0);
`else
    // Without the timer an access waits for its ack forever; TIMEOUT has no effect.
    assign w_tmr_zero = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_alu       <= '0;
            r_wdata     <= '0;
            r_wbs       <= 1'b0;
            r_ni        <= 1'b0;
            r_mem_data  <= '0;
            r_out_valid <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_wbs   <= in_wbs;
                        r_ni    <= in_ni;
                        r_alu   <= in_alu_result;
                        r_wdata <= in_write_data;
                        // read+write together is handled as a store
                        r_we    <= in_mem_write;
                        if (in_mem_read || in_mem_write) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_mem_data  <= '0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        r_mem_data  <= r_we ? '0 : dmem_rdata;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_tmr_zero) begin
                        r_mem_data  <= '1;
                        r_mem_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall         = (r_state == S_ACCESS);
    assign dmem_req      = (r_state == S_ACCESS);
    assign dmem_we       = r_we;
    assign dmem_addr     = r_alu;
    assign dmem_wdata    = r_wdata;
    assign out_valid     = r_out_valid;
    assign wbs_out       = r_wbs;
    assign ni_out        = r_ni;
    assign memData_out   = r_mem_data;
    assign ALUresult_out = r_alu;
    assign mem_err       = r_mem_err;

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-stage controller that drives the producer side of the memory/writeback pipeline interface. It takes one instruction per transaction from the execute/memory pipeline register and performs the data-memory load or store through a req/ack handshake. It then presents `wbs_out`, `memData_out`, `ALUresult_out` and `ni_out` to the MemoryWriteback register, qualified by a one-cycle `out_valid` pulse. Upstream is stalled while a memory transaction is outstanding.

## Interface
- `DATA_W`, 16, data and address width
- `TIMEOUT`, 15, ACCESS cycles without `dmem_ack` before abort (only with `MEM_TIMEOUT_EN`)

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream instruction present
- `in_wbs`  in  1  writeback select (1 = ALU result, 0 = memory data)
- `in_mem_read`  in  1  load
- `in_mem_write`  in  1  store
- `in_alu_result`  in  DATA_W  ALU result; also the memory address
- `in_write_data`  in  DATA_W  store data
- `in_ni`  in  1  next-instruction flag, passed through
- `stall`  out  1  upstream must hold its inputs
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  DATA_W  address
- `dmem_wdata`  out  DATA_W  store data
- `dmem_rdata`  in  DATA_W  load data, valid with `dmem_ack`
- `dmem_ack`  in  1  transaction complete
- `out_valid`  out  1  one-cycle pulse; results valid
- `wbs_out`, `ni_out`  out  1  captured `in_wbs` / `in_ni`
- `memData_out`  out  DATA_W  load data (0 for non-loads)
- `ALUresult_out`  out  DATA_W  captured ALU result
- `mem_err`  out  1  sticky timeout flag

## Operation
- States: IDLE, ACCESS.
- IDLE, `stall`=0; on `in_valid`:
  - If neither read nor write: capture fields. Next cycle `out_valid`=1 and `memData_out`=0. Remain in IDLE.
  - If read or write: capture fields and enter ACCESS. Both asserted is treated as a write.
- ACCESS:
  - `stall`=1 and `dmem_req`=1, with `dmem_we`/`dmem_addr`/`dmem_wdata` taken from the captured values and held stable.
  - On `dmem_ack`: for a load, `memData_out` <= `dmem_rdata`; for a store, `memData_out` <= 0. `out_valid` pulses next cycle and the state returns to IDLE.
- `dmem_ack` in IDLE is ignored.
- `out_valid` is high for exactly one cycle per accepted instruction. The other outputs hold until the next update.
- `in_valid`=0 in IDLE produces no output activity.
- Data widths are fixed at `DATA_W`; no extension or truncation.

## Timing
- Reset: the state goes to IDLE. All outputs are 0, including `stall`, `dmem_req` and `mem_err`. An in-flight transaction is dropped with no `out_valid`, and `dmem_req` is 0 in the cycle after the reset edge.
- Non-memory instruction: latency 1 cycle from the accept edge to `out_valid`.
- Memory instruction accepted at edge N:
  - `dmem_req`/`stall` are high from cycle N+1.
  - With the earliest ack in cycle N+1, `out_valid` and IDLE occur at N+2.
  - The next instruction is accepted no earlier than edge N+2.
  - Each additional wait cycle adds one cycle.
- `stall` is a registered state decode: high exactly while in ACCESS.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A cycle counter clears on ACCESS entry and increments each ACCESS cycle without `dmem_ack`.
  - When it reaches `TIMEOUT`, the transaction aborts: `dmem_req` drops, `out_valid` pulses with `memData_out`=16'hFFFF, `mem_err`=1 (sticky until `rst`), and the state returns to IDLE.
  - `dmem_ack` in the same cycle as the terminal count wins: normal completion, no error.
- Undefined: no counter. ACCESS waits indefinitely and `mem_err` is tied 0.

## Test plan
- Reset mid-ACCESS (`rst` while `dmem_req`=1) -> next cycle all outputs 0, IDLE, no `out_valid`, and a later `dmem_ack` is ignored.
- ALU-only op, `in_wbs`=1, `in_alu_result`=16'hFF00, `in_ni`=1 -> `out_valid` 1 cycle later with `ALUresult_out`=FF00, `memData_out`=0, `wbs_out`=1, `ni_out`=1, and `stall` never high.
- Load, `in_alu_result`=16'h0002, ack after 3 wait cycles with `dmem_rdata`=16'h00FF -> `dmem_addr`=0002 and `dmem_we`=0 held during ACCESS, `stall` high 4 cycles, `memData_out`=00FF, `wbs_out`=0.
- Store, `in_write_data`=16'h5555, `in_alu_result`=16'hAAAA, ack in the first ACCESS cycle -> `dmem_we`=1, `dmem_wdata`=5555, `out_valid` at accept+2, `memData_out`=0.
- Read and write both asserted -> treated as a store, `dmem_we`=1.
- With `MEM_TIMEOUT_EN` and `TIMEOUT`=15, no ack -> abort after 15 ACCESS cycles with `memData_out`=FFFF and `mem_err`=1 persisting across later good transactions. Ack arriving in the 15th cycle -> normal completion and `mem_err`=0.
